// File: rtl/line_sensor_emulator_if.sv
// Command and sensor bundle between a test controller (master) and the
// line-sensor emulator (slave). The emulator is the transmitting end of the sensor lines.
interface line_sensor_emulator_if;
    logic       start;
    logic [3:0] num_crossings;
    logic       exit_sel;
    logic       abort;
    logic       sensor_l;
    logic       sensor_m;
    logic       sensor_r;
    logic       busy;
    logic       done;
    logic [3:0] crossings_sent;

    modport master (
        output start, num_crossings, exit_sel, abort,
        input  sensor_l, sensor_m, sensor_r, busy, done, crossings_sent
    );

    modport slave (
        input  start, num_crossings, exit_sel, abort,
        output sensor_l, sensor_m, sensor_r, busy, done, crossings_sent
    );
endinterface

// File: rtl/line_sensor_emulator.sv
// Emits 101/000/exit sensor patterns that mimic driving a track with a commanded
// number of crossings. Outputs are flops loaded from the next-state decode.
module line_sensor_emulator #(
    parameter int unsigned LINE_CYCLES  = 8,
    parameter int unsigned CROSS_CYCLES = 3,
    parameter int unsigned EXIT_CYCLES  = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    line_sensor_emulator_if.slave  bus
);

    localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(LINE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CROSS_LAST = CNT_W'(CROSS_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_CYCLES - 1);

    localparam logic [2:0] PAT_LINE  = 3'b101;
    localparam logic [2:0] PAT_CROSS = 3'b000;
    localparam logic [2:0] PAT_ALT   = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LINE  = 3'd1,
        S_CROSS = 3'd2,
        S_EXIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             exit_sel_q, exit_sel_d;
    logic [3:0]       crossings_q, crossings_d;
    logic [2:0]       sensors_q, sensors_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, phase counter and latched run parameters
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        exit_sel_d  = exit_sel_q;
        crossings_d = crossings_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.num_crossings;
                    exit_sel_d  = bus.exit_sel;
                    crossings_d = 4'd0;
                    phase_d     = '0;
                    state_d     = S_LINE;
                end
            end
            S_LINE: begin
                if (bus.abort) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                end else if (phase_q == LINE_LAST) begin
                    phase_d = '0;
                    state_d = (remaining_q == 4'd0) ? S_DONE : S_CROSS;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_CROSS: begin
                if (bus.abort) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                end else if (phase_q == CROSS_LAST) begin
                    phase_d     = '0;
                    crossings_d = crossings_q + 4'd1;
                    remaining_d = remaining_q - 4'd1;
                    state_d     = S_EXIT;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_EXIT: begin
                if (bus.abort) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                end else if (phase_q == EXIT_LAST) begin
                    phase_d = '0;
                    state_d = S_LINE;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                phase_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                phase_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state flops
    always_comb begin
        sensors_d = PAT_LINE;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_d)
            S_LINE: begin
                busy_d = 1'b1;
            end
            S_CROSS: begin
                sensors_d = PAT_CROSS;
                busy_d    = 1'b1;
            end
            S_EXIT: begin
                sensors_d = exit_sel_d ? PAT_ALT : PAT_LINE;
                busy_d    = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                sensors_d = PAT_LINE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            remaining_q <= 4'd0;
            exit_sel_q  <= 1'b0;
            crossings_q <= 4'd0;
            sensors_q   <= PAT_LINE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            exit_sel_q  <= exit_sel_d;
            crossings_q <= crossings_d;
            sensors_q   <= sensors_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.sensor_l       = sensors_q[2];
    assign bus.sensor_m       = sensors_q[1];
    assign bus.sensor_r       = sensors_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.crossings_sent = crossings_q;

endmodule
